// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 32x64 general-purpose register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_32x64_decoder5_32.sv
// Write-enable decoder: one-hot select of the destination register, all zero when disabled.
module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file: two combinational read ports, one synchronous write port, ZERO_REG reads 0.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output reg_data_t rd_data_a,
  output reg_data_t rd_data_b
);

  localparam reg_addr_t ZeroAddr = reg_addr_t'(ZERO_REG);

  logic [NUM_REGS-1:0] wr_onehot;
  reg_data_t           regs_q [NUM_REGS];

  decoder5_32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (wr_onehot)
  );

  // The ZERO_REG slot is never loaded, so it stays a constant zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_onehot[i] && (i != ZERO_REG)) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  function automatic reg_data_t read_port(input reg_addr_t addr);
    reg_data_t val;
    val = regs_q[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!reset && wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end
`else
    // Collisions return the old stored value.
`endif
    if (addr == ZeroAddr) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry, 64-bit general-purpose register file for the single-cycle datapath.
- Write side: a 5-to-32 enable decoder plus per-register load-enabled flops. This is the write-side counterpart of the 64-bit read-select muxing.
- Two asynchronous read ports feed the ALU operand path. One synchronous write port receives writeback.
- The register at index ZERO_REG always reads zero and ignores writes.

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W
- ZERO_REG, 31, index hardwired to zero

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- wr_en  input  1  write enable (RegWrite)
- wr_addr  input  ADDR_W  destination register index
- wr_data  input  DATA_W  writeback data
- rd_addr_a  input  ADDR_W  read port A index
- rd_addr_b  input  ADDR_W  read port B index
- rd_data_a  output  DATA_W  read port A data
- rd_data_b  output  DATA_W  read port B data

Behaviour:
- Storage:
  - NUM_REGS-1 real DATA_W-bit registers. The ZERO_REG slot has no storage.
- Reset:
  - On a rising edge with reset=1, every stored register becomes 0.
  - Reset has priority over a write in the same cycle; that write is dropped.
  - Asserting reset mid-sequence discards all prior contents. There are no partial results.
  - After reset, rd_data_a and rd_data_b read 0 for every address.
- Write:
  - The decoder drives a one-hot enable: bit wr_addr is set when wr_en=1, otherwise all bits are 0.
  - On a rising edge with reset=0, wr_en=1 and wr_addr!=ZERO_REG, register wr_addr loads wr_data.
  - All other registers hold their value.
  - wr_en=0 means no register changes, whatever wr_addr holds.
  - Writes to ZERO_REG are silently discarded.
- Read:
  - Combinational, zero cycle latency: rd_data_x = reg[rd_addr_x].
  - rd_addr_x==ZERO_REG returns 0.
  - A and B may address the same register; both return the same value.
- Write latency:
  - A value written at edge N is visible on the read ports after edge N, i.e. in cycle N+1.
- Read/write collision, without the optional feature:
  - Same register read and written in the same cycle returns the OLD value.
- Width rules:
  - No sign extension or truncation; the full DATA_W is stored and returned.
  - All 2**ADDR_W addresses are valid, so there is no out-of-range case.
- X-handling:
  - wr_addr and wr_data are don't-care while wr_en=0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr==rd_addr_x and rd_addr_x!=ZERO_REG, rd_data_x returns wr_data combinationally in the same cycle (write-through).
  - Reset still forces read data to 0 only via storage. Bypass is active whenever reset=0.
  - When reset=1, the bypass is suppressed.
- Undefined: no bypass; collisions return the old stored value.
- Storage and write timing are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - localparams DATA_W=64, ADDR_W=5, NUM_REGS=32, ZERO_REG=31
  - typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0])
- Sub-module decoder5_32 (en, addr, onehot[31:0]): combinational enable decoder; the only natural split.
- Read muxing stays inline in regfile_32x64.

Test Plan:
- Reset clears state: write 0xDEAD_BEEF to X3, then pulse reset one cycle -> rd_addr_a=3 reads 0. Also, reset=1 with wr_en=1, wr_addr=4 -> X4 remains 0.
- Write then read all registers: write index i*0x0101_0101_0101_0101 to X0..X30 on consecutive cycles. Then -> both ports read back every value; X31 reads 0.
- Zero register: wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF -> rd_addr_a=31 and rd_addr_b=31 both read 0 next cycle.
- Write-enable gating: wr_en=0, wr_addr=5, wr_data=-2418 with X5=100 -> X5 still 100. Next cycle, wr_en=1 -> X5 reads -2418 (0xFFFF_FFFF_FFFF_F68E).
- Collision, both builds: X7=10, same cycle wr_en=1, wr_addr=7, wr_data=10000, rd_addr_a=7:
  - Without macro -> rd_data_a=10 before the edge, 10000 after.
  - With REGFILE_WRITE_BYPASS_EN -> 10000 before the edge.
  - rd_addr_b=31 stays 0 in both builds.
- Dual-port independence: X1=64, X2=1, rd_addr_a=1, rd_addr_b=2, then swap addresses -> outputs swap in the same cycle with no clock edge needed.
